// File: rtl/therm_dwa_decoder.sv
// Thermometer / data-weighted-averaging element selector for a unit-element DAC.
// Samples an unsigned code on en, clamps it to N_ELEM, and registers the enables.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   en          - sample strobe; mode and code are consumed only when high
//   mode        - 0 static thermometer, 1 DWA rotation
//   code        - requested number of active elements (clamped to N_ELEM)
//   sel         - registered element enables
//   ptr         - registered rotation pointer (next element to use)
//   valid_out   - one-cycle pulse when sel updates
//   ovf         - pulses with valid_out when the sampled code was clamped
module therm_dwa_decoder #(
    parameter int IN_W   = 3,
    parameter int N_ELEM = 6,
    parameter int PTR_W  = $clog2(N_ELEM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [IN_W-1:0]   code,
    output logic [N_ELEM-1:0] sel,
    output logic [PTR_W-1:0]  ptr,
    output logic              valid_out,
    output logic              ovf
);

    // SW holds values up to 2*N_ELEM-1 (pointer plus clamped count).
    localparam int SW = PTR_W + 1;
    localparam int CW = (IN_W > SW) ? IN_W : SW;
    localparam logic [CW-1:0] N_CW = CW'(N_ELEM);
    localparam logic [SW-1:0] N_SW = SW'(N_ELEM);

    logic [N_ELEM-1:0] sel_d, sel_q;
    logic [PTR_W-1:0]  ptr_d, ptr_q;
    logic              valid_d, valid_q;
    logic              ovf_d, ovf_q;

    logic              clamp;
    logic [SW-1:0]     k;
    logic [SW-1:0]     ptr_ext;
    logic [SW-1:0]     ptr_sum;
    logic [N_ELEM-1:0] therm;
    logic [N_ELEM-1:0] rot;

    always_comb begin
        clamp   = CW'(code) > N_CW;
        k       = clamp ? N_SW : SW'(code);
        ptr_ext = {1'b0, ptr_q};
        ptr_sum = ptr_ext + k;
        therm   = '0;
        rot     = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            therm[i] = SW'(i) < k;
            // Element i is on when its distance ahead of ptr (mod N) is below k.
            rot[i] = ((SW'(i) >= ptr_ext) ? SW'(i) - ptr_ext
                                          : SW'(i) + N_SW - ptr_ext) < k;
        end
    end

    always_comb begin
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        ovf_d   = 1'b0;
        if (en) begin
            valid_d = 1'b1;
            ovf_d   = clamp;
            if (mode) begin
                sel_d = rot;
                // ptr + k < 2*N_ELEM, so one conditional subtract wraps it.
                ptr_d = PTR_W'((ptr_sum >= N_SW) ? ptr_sum - N_SW : ptr_sum);
            end else begin
                sel_d = therm;
                ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sel       = sel_q;
    assign ptr       = ptr_q;
    assign valid_out = valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_therm_dwa_decoder.sv
// Self-checking bench for therm_dwa_decoder at default parameters.
// Directed scenarios plus a randomized DWA stream against a modulo-arithmetic model.
module tb_therm_dwa_decoder;

    localparam int N = 6;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         mode;
    logic [2:0]   code;
    logic [N-1:0] sel;
    logic [2:0]   ptr;
    logic         valid_out;
    logic         ovf;

    int checks;
    int errors;

    therm_dwa_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .code      (code),
        .sel       (sel),
        .ptr       (ptr),
        .valid_out (valid_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int           m_ptr;
    logic [N-1:0] m_sel;
    logic         m_valid;
    logic         m_ovf;

    task automatic model_step(input logic e, input logic m, input int c);
        int kk;
        m_valid = e;
        m_ovf   = 1'b0;
        if (e) begin
            kk    = (c > N) ? N : c;
            m_ovf = (c > N);
            m_sel = '0;
            if (m) begin
                for (int j = 0; j < kk; j++) m_sel[(m_ptr + j) % N] = 1'b1;
                m_ptr = (m_ptr + kk) % N;
            end else begin
                for (int j = 0; j < kk; j++) m_sel[j] = 1'b1;
                m_ptr = 0;
            end
        end
    endtask

    task automatic drive(input logic e, input logic m, input logic [2:0] c);
        @(negedge clk);
        en   = e;
        mode = m;
        code = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ptr   = 0;
        m_sel   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        mode  = 1'b1;
        code  = 3'd5;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sel, ptr, valid_out, ovf} !== 11'b0) begin
            errors++;
            $display("FAIL reset obs=%b exp=%b", {sel, ptr, valid_out, ovf}, 11'b0);
        end
        do_reset();
    endtask

    task automatic test_dwa_seq();
        logic [2:0]  codes[4] = '{3'd3, 3'd4, 3'd6, 3'd0};
        logic [10:0] expv[4]  = '{11'b000111_011_1_0, 11'b111001_001_1_0,
                                  11'b111111_001_1_0, 11'b000000_001_1_0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, codes[i]);
            checks++;
            if ({sel, ptr, valid_out, ovf} !== expv[i]) begin
                errors++;
                $display("FAIL dwa_seq[%0d] obs=%b exp=%b", i,
                         {sel, ptr, valid_out, ovf}, expv[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [2:0]  codes[2] = '{3'd7, 3'd2};
        logic [10:0] expv[2]  = '{11'b111111_001_1_1, 11'b000110_011_1_0};
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, codes[i]);
            checks++;
            if ({sel, ptr, valid_out, ovf} !== expv[i]) begin
                errors++;
                $display("FAIL overflow[%0d] obs=%b exp=%b", i,
                         {sel, ptr, valid_out, ovf}, expv[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 3'($urandom_range(0, 7)));
            checks++;
            if ({sel, ptr, valid_out, ovf} !== 11'b000110_011_0_0) begin
                errors++;
                $display("FAIL hold[%0d] obs=%b exp=%b", i,
                         {sel, ptr, valid_out, ovf}, 11'b000110_011_0_0);
            end
        end
    endtask

    task automatic test_static();
        logic        modes[3] = '{1'b0, 1'b0, 1'b1};
        logic [2:0]  codes[3] = '{3'd4, 3'd1, 3'd2};
        logic [10:0] expv[3]  = '{11'b001111_000_1_0, 11'b000001_000_1_0,
                                  11'b000011_010_1_0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, modes[i], codes[i]);
            checks++;
            if ({sel, ptr, valid_out, ovf} !== expv[i]) begin
                errors++;
                $display("FAIL static[%0d] obs=%b exp=%b", i,
                         {sel, ptr, valid_out, ovf}, expv[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b1, 3'd3);
        drive(1'b1, 1'b1, 3'd4);
        checks++;
        if (sel !== 6'b111001) begin
            errors++;
            $display("FAIL async_pre sel=%b exp=%b", sel, 6'b111001);
        end
        en   = 1'b1;
        mode = 1'b1;
        code = 3'd5;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sel, ptr, valid_out, ovf} !== 11'b0) begin
            errors++;
            $display("FAIL async_now obs=%b exp=%b", {sel, ptr, valid_out, ovf}, 11'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({sel, ptr, valid_out, ovf} !== 11'b0) begin
            errors++;
            $display("FAIL async_held obs=%b exp=%b", {sel, ptr, valid_out, ovf}, 11'b0);
        end
        #1;
        code  = 3'd2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({sel, ptr, valid_out, ovf} !== 11'b000011_010_1_0) begin
            errors++;
            $display("FAIL async_first obs=%b exp=%b",
                     {sel, ptr, valid_out, ovf}, 11'b000011_010_1_0);
        end
        en = 1'b0;
    endtask

    task automatic test_random_dwa();
        int   use_cnt[N];
        int   mx;
        int   mn;
        logic e;
        int   c;
        do_reset();
        for (int i = 0; i < N; i++) use_cnt[i] = 0;
        for (int n = 0; n < 10000; n++) begin
            e = ($urandom_range(0, 7) != 0);
            c = $urandom_range(0, 7);
            drive(e, 1'b1, 3'(c));
            model_step(e, 1'b1, c);
            checks++;
            if ({sel, ptr, valid_out, ovf} !== {m_sel, 3'(m_ptr), m_valid, m_ovf}) begin
                errors++;
                $display("FAIL rand_dwa[%0d] obs=%b exp=%b", n,
                         {sel, ptr, valid_out, ovf},
                         {m_sel, 3'(m_ptr), m_valid, m_ovf});
            end
            if (valid_out) begin
                for (int i = 0; i < N; i++) use_cnt[i] += int'(sel[i]);
                mx = use_cnt[0];
                mn = use_cnt[0];
                for (int i = 1; i < N; i++) begin
                    if (use_cnt[i] > mx) mx = use_cnt[i];
                    if (use_cnt[i] < mn) mn = use_cnt[i];
                end
                checks++;
                if (mx - mn > 1) begin
                    errors++;
                    $display("FAIL usage_spread[%0d] spread=%0d max_allowed=1", n, mx - mn);
                end
            end
        end
    endtask

    task automatic test_random_mixed();
        logic e;
        logic m;
        int   c;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 3) != 0);
            m = ($urandom_range(0, 3) != 0);
            c = $urandom_range(0, 7);
            drive(e, m, 3'(c));
            model_step(e, m, c);
            checks++;
            if ({sel, ptr, valid_out, ovf} !== {m_sel, 3'(m_ptr), m_valid, m_ovf}) begin
                errors++;
                $display("FAIL rand_mixed[%0d] obs=%b exp=%b", n,
                         {sel, ptr, valid_out, ovf},
                         {m_sel, 3'(m_ptr), m_valid, m_ovf});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        en     = 1'b0;
        mode   = 1'b0;
        code   = '0;
        rst_n  = 1'b0;
        m_ptr  = 0;
        m_sel  = '0;
        test_reset();
        test_dwa_seq();
        test_overflow();
        test_hold();
        test_static();
        test_async_reset();
        test_random_dwa();
        test_random_mixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
